bram_arbiter: RTL
=================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of the RAM word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: RAM address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 bit each: the requester presents a transaction.
REQ-006 SHALL have ports req0_we / req1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports req0_addr / req1_addr, input, ADDR_WIDTH bits each: the target word.
REQ-008 SHALL have ports req0_wdata / req1_wdata, input, WIDTH bits each: the write data.
REQ-009 SHALL have ports req0_ready / req1_ready, output, 1 bit each: grant; the transaction is accepted when valid and ready are both 1.
REQ-010 SHALL have ports rsp0_valid / rsp1_valid, output, 1 bit each: response strobe.
REQ-011 SHALL have ports rsp0_data / rsp1_data, output, WIDTH bits each: response data.
REQ-012 SHALL have ports ram_en and ram_we, output, 1 bit each: the enable and write controls of the single-port write-first RAM.
REQ-013 SHALL have port ram_addr, output, ADDR_WIDTH bits, and port ram_di, output, WIDTH bits: the RAM address and write data.
REQ-014 SHALL have port ram_dout, input, WIDTH bits: the registered RAM output, valid one cycle after ram_en.
REQ-015 SHALL have port conflict_cnt, output, 16 bits: saturating count of cycles in which both requesters are valid.

Function
REQ-016 SHALL compute reqN_ready combinationally from the valids and the priority pointer prio; at most one ready SHALL be 1 in any cycle.
REQ-017 SHALL grant the only valid requester when exactly one is valid, and grant requester prio when both are valid.
REQ-018 SHALL, on every grant to requester i, set prio to the other requester (1-i) at the next edge; with no grant, prio SHALL hold.
REQ-019 SHALL register the granted transaction into ram_en=1, ram_we, ram_addr and ram_di at the acceptance edge, so the RAM samples them one edge later.
REQ-020 SHALL drive ram_en=0 in any cycle following a cycle with no grant; ram_we, ram_addr and ram_di SHALL then hold their previous values.
REQ-021 SHALL carry a 2-stage owner/valid tag pipeline alongside each transaction.
REQ-022 SHALL assert rspN_valid for exactly 1 cycle, 2 cycles after acceptance (accept in cycle T gives response in T+2), for reads and writes alike.
REQ-023 SHALL drive rspN_data = ram_dout; for writes this equals the written data (write-first).
REQ-024 SHALL provide no response backpressure; responses SHALL be returned in acceptance order.
REQ-025 SHALL sustain a throughput of 1 transaction per cycle, including alternating back-to-back grants.
REQ-026 SHALL hold rspN_data at its last value while rspN_valid=0.
REQ-027 SHALL have no address-hazard logic: a read accepted the cycle after a write to the same address returns the new data, because the RAM is single-port and updates sequentially.
REQ-028 SHALL increment conflict_cnt by 1 for each cycle with req0_valid=1 and req1_valid=1, saturating at 0xFFFF.
REQ-029 SHALL ignore reqN_we, reqN_addr and reqN_wdata while reqN_valid=0.

Reset
REQ-030 SHALL, while rst=1, force ram_en=0, ram_we=0, ram_addr=0, ram_di=0, rsp0_valid=0, rsp1_valid=0, rsp0_data=0, rsp1_data=0, conflict_cnt=0, prio=0 and all tag-pipeline valids=0, asynchronously.
REQ-031 SHALL force req0_ready=0 and req1_ready=0 while rst=1.
REQ-032 SHALL, when rst asserts mid-operation, drop in-flight transactions with no rsp_valid ever issued for them; RAM contents are outside this block and are unaffected except by a write already sampled by the RAM.
REQ-033 SHALL accept a transaction in the first cycle after rst deasserts.

Verification
REQ-034 SHALL cover a single write then read: req0 writes addr 5 data 0xA5 at T0, then reads addr 5 at T1 -> rsp0_valid at T2 with data 0xA5 and at T3 with data 0xA5; req1 sees no response.
REQ-035 SHALL cover contention: both requesters valid for 4 cycles from reset -> grants 0,1,0,1; conflict_cnt=4; responses alternate rsp0/rsp1 from T2.
REQ-036 SHALL cover the idle gap: a single req1 read of addr 3 followed by 2 idle cycles -> ram_en=1 for one cycle only; rsp1_valid 2 cycles after acceptance; no further responses.
REQ-037 SHALL cover saturation: both requesters valid for 65540 cycles -> conflict_cnt=0xFFFF and holds.
REQ-038 SHALL cover reset mid-flight: rst pulsed in the cycle after acceptance -> no rsp_valid; all outputs 0; a request in the first cycle after rst deasserts is accepted.
REQ-039 SHALL cover the write-first response: req1 writes 0x3C to addr 0x3FF -> rsp1_data=0x3C after 2 cycles; a following read of addr 0x3FF returns 0x3C.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single-port write-first BRAM with a registered output.
// Each accepted transaction returns exactly one response, two cycles after acceptance.
module bram_arbiter #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]      req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]      req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [WIDTH-1:0]      rsp0_data,
  output logic                  rsp1_valid,
  output logic [WIDTH-1:0]      rsp1_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_di,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic [15:0]           conflict_cnt
);

  typedef enum logic {PRIO_REQ0 = 1'b0, PRIO_REQ1 = 1'b1} prio_t;

  prio_t                 r_prio;
  prio_t                 w_prioNext;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_accept;
  logic                  r_ramEn;
  logic                  r_ramWe;
  logic [ADDR_WIDTH-1:0] r_ramAddr;
  logic [WIDTH-1:0]      r_ramDi;
  logic                  r_tag1Valid;
  logic                  r_tag1Owner;
  logic                  r_tag2Valid;
  logic                  r_tag2Owner;
  logic [WIDTH-1:0]      r_rsp0Hold;
  logic [WIDTH-1:0]      r_rsp1Hold;
  logic [15:0]           r_conflictCnt;
  logic                  w_rsp0Valid;
  logic                  w_rsp1Valid;

  // Priority only matters on contention; the loser of a grant gets the next tie.
  always_comb begin
    w_grant0   = 1'b0;
    w_grant1   = 1'b0;
    w_prioNext = r_prio;
    if (!rst) begin
      if (req0_valid && (!req1_valid || r_prio == PRIO_REQ0)) begin
        w_grant0   = 1'b1;
        w_prioNext = PRIO_REQ1;
      end else if (req1_valid) begin
        w_grant1   = 1'b1;
        w_prioNext = PRIO_REQ0;
      end
    end
  end

  assign w_accept   = w_grant0 | w_grant1;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= PRIO_REQ0;
    end else begin
      r_prio <= w_prioNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ramEn   <= 1'b0;
      r_ramWe   <= 1'b0;
      r_ramAddr <= '0;
      r_ramDi   <= '0;
    end else begin
      r_ramEn <= w_accept;
      if (w_accept) begin
        r_ramWe   <= w_grant0 ? req0_we    : req1_we;
        r_ramAddr <= w_grant0 ? req0_addr  : req1_addr;
        r_ramDi   <= w_grant0 ? req0_wdata : req1_wdata;
      end
    end
  end

  // Stage 1 lines up with the RAM command, stage 2 with the registered RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag1Valid <= 1'b0;
      r_tag1Owner <= 1'b0;
      r_tag2Valid <= 1'b0;
      r_tag2Owner <= 1'b0;
    end else begin
      r_tag1Valid <= w_accept;
      r_tag1Owner <= w_grant1;
      r_tag2Valid <= r_tag1Valid;
      r_tag2Owner <= r_tag1Owner;
    end
  end

  assign w_rsp0Valid = r_tag2Valid & ~r_tag2Owner;
  assign w_rsp1Valid = r_tag2Valid &  r_tag2Owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp0Hold <= '0;
      r_rsp1Hold <= '0;
    end else begin
      if (w_rsp0Valid) r_rsp0Hold <= ram_dout;
      if (w_rsp1Valid) r_rsp1Hold <= ram_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conflictCnt <= '0;
    end else if (req0_valid && req1_valid && r_conflictCnt != 16'hFFFF) begin
      r_conflictCnt <= r_conflictCnt + 16'd1;
    end
  end

  assign rsp0_valid   = w_rsp0Valid;
  assign rsp1_valid   = w_rsp1Valid;
  assign rsp0_data    = w_rsp0Valid ? ram_dout : r_rsp0Hold;
  assign rsp1_data    = w_rsp1Valid ? ram_dout : r_rsp1Hold;
  assign ram_en       = r_ramEn;
  assign ram_we       = r_ramWe;
  assign ram_addr     = r_ramAddr;
  assign ram_di       = r_ramDi;
  assign conflict_cnt = r_conflictCnt;

endmodule
